// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: round-robin arbiter that shows one requester's byte for a fixed dwell, plus a free-running digit-refresh strobe.
// Optional feature: define SEG_SCHED_PREEMPT_EN to let requester 0 preempt a dwell owned by requesters 1-3.
module seg_display_scheduler #(
    parameter int DWELL_CYCLES = 12000000,
    parameter int REFRESH_DIV  = 12000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [3:0]  REQ,
    input  logic [31:0] DATA,
    output logic [7:0]  BCD,
    output logic        BLANK,
    output logic [3:0]  GNT,
    output logic [3:0]  ACK,
    output logic        REFRESH_TICK,
    output logic        BUSY
);
    localparam int DW = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;
    localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SHOW = 1'b1;

    logic [0:0]    state;
    logic [1:0]    ptr;
    logic [1:0]    cur;
    logic [1:0]    win;
    logic          any_req;
    logic [DW-1:0] dwell;
    logic [RW-1:0] rcnt;

    // Pick the first asserted request starting at the pointer; scanning backwards lets the nearest one win.
    always_comb begin
        any_req = |REQ;
        win = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (REQ[ptr + 2'(k)]) win = ptr + 2'(k);
        end
    end

    // Arbitration and dwell sequencing; BCD/BLANK only change on a grant or reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            GNT   <= 4'b0000;
            ACK   <= 4'b0000;
            BCD   <= 8'h00;
            BLANK <= 1'b1;
            ptr   <= 2'd0;
            cur   <= 2'd0;
            dwell <= '0;
        end else if (state == IDLE) begin
            ACK <= 4'b0000;
            GNT <= 4'b0000;
            if (any_req) begin
                state <= SHOW;
                BUSY  <= 1'b1;
                GNT   <= 4'b0001 << win;
                ACK   <= 4'b0001 << win;
                BCD   <= DATA[{win, 3'b000} +: 8];
                BLANK <= 1'b0;
                cur   <= win;
                dwell <= '0;
            end
`ifdef SEG_SCHED_PREEMPT_EN
        end else if (REQ[0] && cur != 2'd0) begin
            GNT   <= 4'b0001;
            ACK   <= 4'b0001;
            BCD   <= DATA[7:0];
            cur   <= 2'd0;
            dwell <= '0;
`endif
        end else begin
            ACK <= 4'b0000;
            if (dwell == DWELL_LAST) begin
                state <= IDLE;
                BUSY  <= 1'b0;
                GNT   <= 4'b0000;
                ptr   <= cur + 2'd1;
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

    // Free-running refresh divider, independent of arbitration.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rcnt         <= '0;
            REFRESH_TICK <= 1'b0;
        end else begin
            REFRESH_TICK <= rcnt == REFRESH_LAST;
            rcnt         <= rcnt == REFRESH_LAST ? '0 : rcnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_seg_display_scheduler.sv
// tb_seg_display_scheduler: directed scoreboard bench for seg_display_scheduler with DWELL_CYCLES=4, REFRESH_DIV=3.
module tb_seg_display_scheduler;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic [3:0]  REQ;
    logic [31:0] DATA;
    logic [7:0]  BCD;
    logic        BLANK;
    logic [3:0]  GNT;
    logic [3:0]  ACK;
    logic        REFRESH_TICK;
    logic        BUSY;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] bcd;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    seg_display_scheduler #(.DWELL_CYCLES(4), .REFRESH_DIV(3)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .DATA(DATA), .BCD(BCD), .BLANK(BLANK),
        .GNT(GNT), .ACK(ACK), .REFRESH_TICK(REFRESH_TICK), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [7:0] b);
        exp_t e;
        e.gnt = g;
        e.bcd = b;
        sb.push_back(e);
    endtask

    // Monitor: every ACK pulse is a grant event and must match the next queued expectation.
    always @(negedge CLK) begin
        if (RST_N === 1'b1 && ACK !== 4'b0000) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {28'd0, ACK}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("grant_ack", {28'd0, ACK}, {28'd0, e.gnt});
                chk("grant_gnt", {28'd0, GNT}, {28'd0, e.gnt});
                chk("grant_bcd", {24'd0, BCD}, {24'd0, e.bcd});
                chk("grant_blank", {31'd0, BLANK}, 32'd0);
            end
        end
    end

    initial begin
        logic [3:0] eg;
        RST_N = 1'b0;
        REQ   = 4'b1111;
        DATA  = 32'h44332211;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_blank", {31'd0, BLANK}, 32'd1);
        chk("rst_bcd", {24'd0, BCD}, 32'd0);
        chk("rst_gnt", {28'd0, GNT}, 32'd0);
        chk("rst_ack", {28'd0, ACK}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_tick", {31'd0, REFRESH_TICK}, 32'd0);

        push(4'b0001, 8'h11);
        push(4'b0010, 8'h22);
        push(4'b0100, 8'h33);
        push(4'b1000, 8'h44);
        push(4'b0001, 8'h11);
        RST_N = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge CLK);
            eg = ((c - 1) % 5) < 4 ? 4'b0001 << (((c - 1) / 5) % 4) : 4'b0000;
            chk("rr_gnt", {28'd0, GNT}, {28'd0, eg});
            chk("rr_busy", {31'd0, BUSY}, {31'd0, eg != 4'b0000});
            chk("tick", {31'd0, REFRESH_TICK}, {31'd0, (c % 3) == 0});
        end

        RST_N = 1'b0;
        REQ   = 4'b0000;
        @(negedge CLK);
        RST_N = 1'b1;
        REQ   = 4'b0100;
        DATA  = 32'h005A0000;
        push(4'b0100, 8'h5A);
        for (int c = 1; c <= 6; c++) begin
            @(negedge CLK);
            if (c == 1) begin
                REQ  = 4'b0000;
                DATA = 32'hFFFFFFFF;
            end
            chk("single_gnt", {28'd0, GNT}, c <= 4 ? 32'h4 : 32'h0);
            chk("single_bcd", {24'd0, BCD}, 32'h5A);
            chk("single_blank", {31'd0, BLANK}, 32'd0);
        end

        REQ  = 4'b1000;
        DATA = 32'h77000000;
        push(4'b1000, 8'h77);
        @(negedge CLK);
        chk("r3_c1_gnt", {28'd0, GNT}, 32'h8);
        @(negedge CLK);
        chk("r3_c2_gnt", {28'd0, GNT}, 32'h8);
        RST_N = 1'b0;
        @(negedge CLK);
        chk("abort_gnt", {28'd0, GNT}, 32'h0);
        chk("abort_blank", {31'd0, BLANK}, 32'd1);
        chk("abort_bcd", {24'd0, BCD}, 32'h0);
        chk("abort_ack", {28'd0, ACK}, 32'h0);
        chk("abort_busy", {31'd0, BUSY}, 32'd0);
        RST_N = 1'b1;
        REQ   = 4'b1111;
        DATA  = 32'h44332211;
        push(4'b0001, 8'h11);
        @(negedge CLK);
        chk("post_abort_gnt", {28'd0, GNT}, 32'h1);
        REQ = 4'b0010;
        repeat (3) @(negedge CLK);
        chk("r0_dwell_gnt", {28'd0, GNT}, 32'h1);
        @(negedge CLK);
        chk("r0_idle_gnt", {28'd0, GNT}, 32'h0);
        push(4'b0010, 8'h22);
        @(negedge CLK);
        chk("r1_c1_gnt", {28'd0, GNT}, 32'h2);
        @(negedge CLK);
        REQ  = 4'b0011;
        DATA = 32'h4433223C;
`ifdef SEG_SCHED_PREEMPT_EN
        push(4'b0001, 8'h3C);
        @(negedge CLK);
        chk("preempt_gnt", {28'd0, GNT}, 32'h1);
        chk("preempt_bcd", {24'd0, BCD}, 32'h3C);
        REQ = 4'b0000;
        repeat (3) @(negedge CLK);
        chk("preempt_dwell_gnt", {28'd0, GNT}, 32'h1);
        @(negedge CLK);
        chk("preempt_end_gnt", {28'd0, GNT}, 32'h0);
`else
        @(negedge CLK);
        chk("nopre_c3_gnt", {28'd0, GNT}, 32'h2);
        @(negedge CLK);
        chk("nopre_c4_gnt", {28'd0, GNT}, 32'h2);
        push(4'b0001, 8'h3C);
        @(negedge CLK);
        chk("nopre_idle_gnt", {28'd0, GNT}, 32'h0);
        @(negedge CLK);
        chk("nopre_r0_gnt", {28'd0, GNT}, 32'h1);
        REQ = 4'b0000;
`endif
        repeat (6) @(negedge CLK);
        chk("final_gnt", {28'd0, GNT}, 32'h0);
        chk("final_bcd", {24'd0, BCD}, 32'h3C);
        chk("final_blank", {31'd0, BLANK}, 32'd0);
        chk("final_busy", {31'd0, BUSY}, 32'd0);
        chk("pending_grants", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
